lm_sm_sequencer: RTL and testbench

Multi-cycle controller for load-multiple (LM) and store-multiple (SM) instructions in the 5-stage pipeline. It sits beside the register-read/execute boundary, accepts one LM/SM, and expands it into one memory micro-op per set bit of the 8-bit register mask, with consecutive addresses. While busy it stalls fetch/decode and drives the register index and address consumed by the memory stage.

---
 rtl/lm_sm_sequencer.sv | 148 ++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op sequencer: expands one load/store-multiple into one memory op per mask bit.
// Optional base-register writeback state enabled by defining LMSM_BASE_WB_EN.
module lm_sm_sequencer #(
  parameter int          ADDR_W = 16,
  parameter logic [3:0]  OP_LM  = 4'b0110,
  parameter logic [3:0]  OP_SM  = 4'b0111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       IR,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  input  logic              flush,
  output logic              busy,
  output logic              uop_valid,
  output logic              uop_load,
  output logic [2:0]        uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic              done
`ifdef LMSM_BASE_WB_EN
  ,
  output logic              wb_valid,
  output logic [2:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_data
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          mask_reg, mask_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                load_reg, load_next;
  logic                done_reg, done_next;
  logic [2:0]          wb_idx_reg, wb_idx_next;

  logic [3:0]          opcode;
  logic                is_mem_multi;
  logic [7:0]          mask_rest;
  logic                last_bit;
  logic [2:0]          lsb_idx;
  logic                unused_ir;

  assign opcode       = IR[15:12];
  assign is_mem_multi = (opcode == OP_LM) || (opcode == OP_SM);
  assign mask_rest    = mask_reg & (mask_reg - 8'd1);
  assign last_bit     = (mask_reg != 8'd0) && (mask_rest == 8'd0);
  assign unused_ir    = ^IR[11:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      mask_reg   <= 8'd0;
      addr_reg   <= '0;
      load_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wb_idx_reg <= 3'd0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      addr_reg   <= addr_next;
      load_reg   <= load_next;
      done_reg   <= done_next;
      wb_idx_reg <= wb_idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    addr_next   = addr_reg;
    load_next   = load_reg;
    wb_idx_next = wb_idx_reg;
    done_next   = 1'b0;

    // Lowest set bit wins: scan from the top so the last hit is the smallest index.
    lsb_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) lsb_idx = 3'(i);
    end

    if (flush) begin
      state_next = ST_IDLE;
      mask_next  = 8'd0;
    end else if (!hold) begin
      case (state_reg)
        ST_IDLE: begin
          if (start && is_mem_multi) begin
            mask_next   = IR[7:0];
            addr_next   = base_addr;
            load_next   = (opcode == OP_LM);
            wb_idx_next = IR[11:9];
            if (IR[7:0] != 8'd0) begin
              state_next = ST_RUN;
            end else begin
`ifdef LMSM_BASE_WB_EN
              state_next = ST_WB;
`else
              done_next  = 1'b1;
`endif
            end
          end
        end
        ST_RUN: begin
          mask_next = mask_rest;
          addr_next = addr_reg + ADDR_W'(1);
          if (last_bit) begin
`ifdef LMSM_BASE_WB_EN
            state_next = ST_WB;
`else
            state_next = ST_IDLE;
            done_next  = 1'b1;
`endif
          end
        end
`ifdef LMSM_BASE_WB_EN
        ST_WB: begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign uop_valid = (state_reg == ST_RUN) && !hold && !flush;
  assign uop_last  = uop_valid && last_bit;
  assign uop_load  = load_reg;
  assign uop_reg   = lsb_idx;
  assign uop_addr  = addr_reg;
  assign done      = done_reg;

`ifdef LMSM_BASE_WB_EN
  // addr_reg has advanced once per issued micro-op, so it already holds base + popcount.
  assign wb_valid = (state_reg == ST_WB) && !hold && !flush;
  assign wb_reg   = wb_idx_reg;
  assign wb_data  = addr_reg;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed plan vectors plus randomized
// transactions checked against a queue-of-expected-micro-ops reference model.
module tb_lm_sm_sequencer;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic        clk = 1'b0;
  logic        reset, start, hold, flush;
  logic [15:0] IR, base_addr;
  logic        busy, uop_valid, uop_load, uop_last, done;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;
`ifdef LMSM_BASE_WB_EN
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
`endif

  int   total = 0;
  int   bad   = 0;
  logic exp_done = 1'b0;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
  } uop_t;

  lm_sm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .IR(IR), .base_addr(base_addr),
    .hold(hold), .flush(flush), .busy(busy), .uop_valid(uop_valid),
    .uop_load(uop_load), .uop_reg(uop_reg), .uop_addr(uop_addr),
    .uop_last(uop_last), .done(done)
`ifdef LMSM_BASE_WB_EN
    , .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
`endif
  );

  always #5 clk = ~clk;

  // One transaction: accept cycle, then one cycle per expected micro-op or stall.
  task automatic run_txn(input logic [3:0] op, input logic [7:0] mask, input logic [15:0] base,
                         input logic [15:0] hold_pat, input int flush_at, input bit rnd);
    uop_t        q[$];
    uop_t        u;
    logic [15:0] a;
    bit          acc, is_lm, flushed, exp_v;
    int          k;
    acc     = (op == OP_LM) || (op == OP_SM);
    is_lm   = (op == OP_LM);
    flushed = 1'b0;
    a       = base;
    if (acc) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          u.r = 3'(i);
          u.a = a;
          q.push_back(u);
          a = a + 16'd1;
        end
      end
    end
    @(negedge clk);
    start = 1'b1; IR = {op, 4'($urandom), mask}; base_addr = base; hold = 1'b0; flush = 1'b0;
    #1;
    $display("txn op=%h mask=%h base=%h uops=%0d", op, mask, base, q.size());
    total++;
    if (done !== exp_done) begin
      bad++; $display("FAIL done_at_accept got=%b want=%b", done, exp_done);
    end
    total++;
    if (busy !== 1'b0 || uop_valid !== 1'b0) begin
      bad++; $display("FAIL idle_at_accept busy=%b uop_valid=%b want 0/0", busy, uop_valid);
    end
    k = 0;
    while (q.size() > 0) begin
      k++;
      if (k > 60) begin
        total++; bad++;
        $display("FAIL cycle_budget got=%0d uops left want 0", q.size());
        break;
      end
      @(negedge clk);
      start     = rnd ? 1'($urandom) : 1'b0;
      IR        = 16'($urandom);
      base_addr = 16'($urandom);
      hold      = rnd ? ($urandom_range(0, 3) == 0) : ((k < 16) ? hold_pat[k] : 1'b0);
      flush     = (k == flush_at) || (rnd && ($urandom_range(0, 39) == 0));
      #1;
      exp_v = !hold && !flush;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL busy_run cyc=%0d busy=%b done=%b want 1/0", k, busy, done);
      end
      total++;
      if (uop_valid !== exp_v) begin
        bad++; $display("FAIL uop_valid cyc=%0d got=%b want=%b", k, uop_valid, exp_v);
      end
      total++;
      if (exp_v) begin
        if (uop_reg !== q[0].r || uop_addr !== q[0].a || uop_load !== is_lm ||
            uop_last !== (q.size() == 1)) begin
          bad++;
          $display("FAIL uop cyc=%0d got r%0d@%h ld=%b last=%b want r%0d@%h ld=%b last=%b",
                   k, uop_reg, uop_addr, uop_load, uop_last, q[0].r, q[0].a, is_lm, (q.size() == 1));
        end
      end else if (uop_last !== 1'b0) begin
        bad++; $display("FAIL uop_last_stall cyc=%0d got=%b want=0", k, uop_last);
      end
      if (flush) begin
        q.delete();
        flushed = 1'b1;
      end else if (!hold) begin
        void'(q.pop_front());
      end
    end
    exp_done = acc && !flushed;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; hold = 1'($urandom); flush = 1'($urandom);
      #1;
      total++;
      if (done !== exp_done || busy !== 1'b0 || uop_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle done=%b busy=%b uop_valid=%b want %b/0/0", done, busy, uop_valid, exp_done);
      end
      exp_done = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; hold = 1'b0; flush = 1'b0; IR = 16'h0; base_addr = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, uop_valid, uop_last, uop_load, done, uop_reg, uop_addr} !== 24'd0) begin
      bad++;
      $display("FAIL reset_state busy=%b v=%b last=%b ld=%b done=%b reg=%0d addr=%h want all 0",
               busy, uop_valid, uop_last, uop_load, done, uop_reg, uop_addr);
    end
    exp_done = 1'b0;
  endtask

  task automatic test_plan;
    run_txn(OP_LM, 8'hA5, 16'h0100, 16'h0000, 0, 1'b0);
    idle_cycles(1);
    run_txn(OP_SM, 8'h00, 16'h1234, 16'h0000, 0, 1'b0);
    idle_cycles(1);
    run_txn(OP_SM, 8'h03, 16'hFFFF, 16'h0000, 0, 1'b0);
    idle_cycles(1);
    run_txn(OP_LM, 8'h0F, 16'h0040, 16'h000C, 0, 1'b0);
    idle_cycles(1);
    run_txn(OP_LM, 8'hFF, 16'h0300, 16'h0000, 3, 1'b0);
    run_txn(OP_SM, 8'h81, 16'h0500, 16'h0000, 0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_ignore;
    run_txn(4'b0001, 8'hFF, 16'h0700, 16'h0000, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; IR = {OP_LM, 4'h0, 8'h01}; hold = 1'b1; flush = 1'b0;
    @(negedge clk);
    hold = 1'b0; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL ignore_hold_flush busy=%b done=%b want 0/0", busy, done);
    end
    exp_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; IR = {OP_LM, 4'h0, 8'hFF}; base_addr = 16'h0900; hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (uop_valid !== 1'b1 || uop_reg !== 3'd1 || uop_addr !== 16'h0901) begin
      bad++; $display("FAIL pre_reset_uop v=%b r%0d@%h want 1 r1@0901", uop_valid, uop_reg, uop_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, uop_valid, uop_last, uop_load, done, uop_reg, uop_addr} !== 24'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b v=%b last=%b ld=%b done=%b reg=%0d addr=%h want all 0",
               busy, uop_valid, uop_last, uop_load, done, uop_reg, uop_addr);
    end
    exp_done = 1'b0;
    run_txn(OP_SM, 8'h42, 16'h0A00, 16'h0000, 0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [7:0] mask;
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0:       op = 4'($urandom);
        1, 2, 3: op = OP_SM;
        default: op = OP_LM;
      endcase
      case ($urandom_range(0, 7))
        0:       mask = 8'h00;
        1:       mask = 8'hFF;
        default: mask = 8'($urandom);
      endcase
      run_txn(op, mask, 16'($urandom), 16'h0000, 0, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset;
    test_plan;
    test_ignore;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
